// File: rtl/mips_cpu_control_fsm.sv
// mips_cpu_control_fsm: multicycle MIPS control unit.
// Sequences FETCH -> DECODE -> EXEC1 -> EXEC2 per instruction and decodes
// opcode/fncode into datapath strobes and mux selects. The only sequential
// state is the FSM register, the memory-wait watchdog and the sticky cause flags.
// Optional feature: define MIPS_CPU_CTRL_TRAP_EN to halt with trap=1 on an
// illegal instruction; left undefined, illegal instructions run as a NOP.
//
// Memory handshake: memread/memwrite are held high for the whole access. The
// access completes in the first cycle it is presented with waitrequest=0; any
// cycle with waitrequest=1 repeats the same access and the FSM does not advance.
module mips_cpu_control_fsm #(
  parameter int ALUOP_W      = 4,
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               waitrequest,
  input  logic [5:0]         opcode,
  input  logic [5:0]         fncode,
  input  logic               halt_req,
  output logic [2:0]         state,
  output logic               active,
  output logic [1:0]         regdst,
  output logic               regwrite,
  output logic               irwrite,
  output logic               pcwrite,
  output logic               pcwritecond,
  output logic               jump,
  output logic               memread,
  output logic               memwrite,
  output logic               branch_ne,
  output logic               iord,
  output logic               alusrca,
  output logic [1:0]         pcsource,
  output logic [1:0]         memtoreg,
  output logic [1:0]         alusrcb,
  output logic [ALUOP_W-1:0] aluop,
  output logic               trap,
  output logic               timeout
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC1  = 3'd2;
  localparam logic [2:0] S_EXEC2  = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(2);

  // Watchdog sizing; with WAIT_TIMEOUT=0 the counter exists but never expires.
  localparam int              WD_W      = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic            WD_EN     = (WAIT_TIMEOUT > 0);
  localparam int              WD_LAST   = (WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0;
  localparam logic [WD_W-1:0] WD_LAST_V = WD_LAST[WD_W-1:0];

  logic [2:0]      state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            is_r_alu, is_jr, is_jalr, is_addiu, is_lw, is_sw;
  logic            is_beq, is_bne, is_j, is_jal, is_jump;
  logic            mem_wait, wd_expire;
`ifdef MIPS_CPU_CTRL_TRAP_EN
  logic            trap_q, trap_d;
  logic            is_legal;
`endif

  // Instruction decode from the instruction register fields.
  always_comb begin
    is_r_alu = (opcode == OP_RTYPE) &&
               ((fncode == FN_ADDU) || (fncode == FN_SUBU) || (fncode == FN_AND) ||
                (fncode == FN_OR)   || (fncode == FN_XOR));
    is_jr    = (opcode == OP_RTYPE) && (fncode == FN_JR);
    is_jalr  = (opcode == OP_RTYPE) && (fncode == FN_JALR);
    is_addiu = (opcode == OP_ADDIU);
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_beq   = (opcode == OP_BEQ);
    is_bne   = (opcode == OP_BNE);
    is_j     = (opcode == OP_J);
    is_jal   = (opcode == OP_JAL);
    is_jump  = is_jr || is_jalr || is_j || is_jal;
`ifdef MIPS_CPU_CTRL_TRAP_EN
    is_legal = is_r_alu || is_jr || is_jalr || is_addiu || is_lw || is_sw ||
               is_beq || is_bne || is_j || is_jal;
`endif
  end

  // Watchdog: counts consecutive stalled memory-access cycles.
  always_comb begin
    mem_wait  = waitrequest &&
                ((state_q == S_FETCH) ||
                 ((state_q == S_EXEC1) && is_lw) ||
                 ((state_q == S_EXEC2) && is_sw));
    wd_expire = WD_EN && mem_wait && (wd_q == WD_LAST_V);
    if (!waitrequest)
      wd_d = '0;
    else if (WD_EN && mem_wait)
      wd_d = wd_q + WD_W'(1);
    else
      wd_d = wd_q;
  end

  // Next-state logic and sticky cause flags.
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q | wd_expire;
`ifdef MIPS_CPU_CTRL_TRAP_EN
    trap_d    = trap_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (wd_expire)
          state_d = S_HALT;
        else if (!waitrequest)
          state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC1;
      S_EXEC1: begin
        state_d = S_EXEC2;
        if (is_lw && waitrequest) state_d = S_EXEC1;
        if (wd_expire) state_d = S_HALT;
`ifdef MIPS_CPU_CTRL_TRAP_EN
        if (!is_legal) begin
          state_d = S_HALT;
          trap_d  = 1'b1;
        end
`endif
      end
      S_EXEC2: begin
        state_d = S_FETCH;
        if (is_sw && waitrequest) state_d = S_EXEC2;
        if (is_jump && halt_req) state_d = S_HALT;
        if (wd_expire) state_d = S_HALT;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // State, watchdog and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wd_q      <= '0;
      timeout_q <= 1'b0;
`ifdef MIPS_CPU_CTRL_TRAP_EN
      trap_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
`ifdef MIPS_CPU_CTRL_TRAP_EN
      trap_q    <= trap_d;
`endif
    end
  end

  // Datapath strobes and mux selects, combinational from state and IR fields.
  always_comb begin
    regdst      = 2'd0;
    regwrite    = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    jump        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    branch_ne   = 1'b0;
    iord        = 1'b0;
    alusrca     = 1'b0;
    pcsource    = 2'd0;
    memtoreg    = 2'd0;
    alusrcb     = 2'd0;
    aluop       = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'd1;
        irwrite = !waitrequest;
        pcwrite = !waitrequest;
      end
      S_DECODE: alusrcb = 2'd3;
      S_EXEC1, S_EXEC2: begin
        if (is_r_alu) begin
          regdst  = 2'd1;
          alusrca = 1'b1;
          aluop   = ALU_FN;
        end
        if (is_jr) pcsource = 2'd3;
        // JALR takes its target from the register path just like JR.
        if (is_jalr) begin
          regdst   = 2'd1;
          memtoreg = 2'd2;
          pcsource = 2'd3;
        end
        if (is_addiu) begin
          alusrca = 1'b1;
          alusrcb = 2'd2;
        end
        if (is_lw) begin
          iord     = 1'b1;
          alusrca  = 1'b1;
          alusrcb  = 2'd2;
          memtoreg = 2'd1;
        end
        if (is_sw) begin
          iord    = 1'b1;
          alusrca = 1'b1;
          alusrcb = 2'd2;
        end
        if (is_beq || is_bne) begin
          alusrca   = 1'b1;
          aluop     = ALU_SUB;
          pcsource  = 2'd1;
          branch_ne = is_bne;
        end
        if (is_j) pcsource = 2'd2;
        if (is_jal) begin
          pcsource = 2'd2;
          regdst   = 2'd2;
          memtoreg = 2'd2;
        end
        if (state_q == S_EXEC1) begin
          regwrite = is_jalr || is_jal;
          memread  = is_lw;
        end else begin
          regwrite    = is_r_alu || is_addiu || is_lw;
          jump        = is_jump;
          memwrite    = is_sw;
          pcwritecond = is_beq || is_bne;
        end
      end
      default: ;
    endcase
    // Reset abandons the instruction; an expiring watchdog drops the pending access.
    if (reset || wd_expire) begin
      regwrite    = 1'b0;
      irwrite     = 1'b0;
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      jump        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
    end
  end

  assign state   = state_q;
  assign active  = !reset && (state_q != S_HALT);
  assign timeout = timeout_q;
`ifdef MIPS_CPU_CTRL_TRAP_EN
  assign trap    = trap_q;
`else
  assign trap    = 1'b0;
`endif

endmodule

// File: tb/tb_mips_cpu_control_fsm.sv
// Bench for mips_cpu_control_fsm (WAIT_TIMEOUT=5). A table-driven model of the
// instruction set predicts every output each cycle; directed scenarios also
// check hand-written traces. Honours MIPS_CPU_CTRL_TRAP_EN like the design.
`timescale 1ns/1ps
module tb_mips_cpu_control_fsm;

  localparam int TO = 5;
  localparam int AW = 4;
`ifdef MIPS_CPU_CTRL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic          clk;
  logic          reset, waitrequest, halt_req;
  logic [5:0]    opcode, fncode;
  logic [2:0]    state;
  logic          active, regwrite, irwrite, pcwrite, pcwritecond, jump;
  logic          memread, memwrite, branch_ne, iord, alusrca, trap, timeout;
  logic [1:0]    regdst, pcsource, memtoreg, alusrcb;
  logic [AW-1:0] aluop;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  mips_cpu_control_fsm #(.ALUOP_W(AW), .WAIT_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .opcode(opcode),
    .fncode(fncode), .halt_req(halt_req), .state(state), .active(active),
    .regdst(regdst), .regwrite(regwrite), .irwrite(irwrite), .pcwrite(pcwrite),
    .pcwritecond(pcwritecond), .jump(jump), .memread(memread), .memwrite(memwrite),
    .branch_ne(branch_ne), .iord(iord), .alusrca(alusrca), .pcsource(pcsource),
    .memtoreg(memtoreg), .alusrcb(alusrcb), .aluop(aluop), .trap(trap),
    .timeout(timeout)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    reset = 1'b1;
    waitrequest = 1'b0;
    halt_req = 1'b0;
    opcode = 6'h00;
    fncode = 6'h00;
  end

  // Instruction table: what each legal op/fn does.
  typedef struct packed {
    logic          legal;
    logic [1:0]    regdst;
    logic          alusrca;
    logic [1:0]    alusrcb;
    logic [AW-1:0] aluop;
    logic [1:0]    pcsource;
    logic [1:0]    memtoreg;
    logic          iord;
    logic          bne;
    logic [1:0]    wr_at;   // 0 none, 1 regwrite in EXEC1, 2 in EXEC2
    logic          jmp;
    logic          ld;
    logic          st;
    logic          br;
  } info_t;

  function automatic info_t lookup(input logic [5:0] op, input logic [5:0] fn);
    info_t r;
    r = '0;
    case (op)
      6'h00: case (fn)
        6'h21, 6'h23, 6'h24, 6'h25, 6'h26: begin
          r.legal = 1; r.regdst = 2'd1; r.alusrca = 1; r.aluop = 4'd2; r.wr_at = 2'd2;
        end
        6'h08: begin r.legal = 1; r.pcsource = 2'd3; r.jmp = 1; end
        6'h09: begin
          r.legal = 1; r.regdst = 2'd1; r.memtoreg = 2'd2; r.pcsource = 2'd3;
          r.wr_at = 2'd1; r.jmp = 1;
        end
        default: ;
      endcase
      6'h09: begin r.legal = 1; r.alusrca = 1; r.alusrcb = 2'd2; r.wr_at = 2'd2; end
      6'h23: begin
        r.legal = 1; r.iord = 1; r.alusrca = 1; r.alusrcb = 2'd2; r.memtoreg = 2'd1;
        r.wr_at = 2'd2; r.ld = 1;
      end
      6'h2B: begin r.legal = 1; r.iord = 1; r.alusrca = 1; r.alusrcb = 2'd2; r.st = 1; end
      6'h04, 6'h05: begin
        r.legal = 1; r.alusrca = 1; r.aluop = 4'd1; r.pcsource = 2'd1; r.br = 1;
        r.bne = (op == 6'h05);
      end
      6'h02: begin r.legal = 1; r.pcsource = 2'd2; r.jmp = 1; end
      6'h03: begin
        r.legal = 1; r.pcsource = 2'd2; r.regdst = 2'd2; r.memtoreg = 2'd2;
        r.wr_at = 2'd1; r.jmp = 1;
      end
      default: ;
    endcase
    return r;
  endfunction

  // Observed trace for the directed literal checks.
  typedef struct packed {
    logic [2:0] st;
    logic       act;
    logic [1:0] rd;
    logic       rw;
    logic       irw;
    logic       mr;
    logic       mw;
    logic       jmp;
    logic       trp;
    logic       tmo;
  } obs_t;
  obs_t obs_q[$];
  logic [2:0] exp_q[$];

  // Model state: phase numbering is the architectural state output.
  int   m_state;
  int   m_wd;
  logic m_trap, m_timeout;
  bit   m_valid = 0;

  // Compare process: predict, compare, then advance the model for the next edge.
  always @(negedge clk) begin : cmp
    info_t      ii;
    logic       stall, expire, w;
    logic [1:0] e_regdst, e_pcsource, e_memtoreg, e_alusrcb;
    logic       e_rw, e_irw, e_pcw, e_pcwc, e_jmp, e_mr, e_mw, e_bne, e_iord, e_asa, e_act;
    logic [AW-1:0] e_aluop;
    logic [27:0] exp_v, act_v;
    obs_t       o;
    cycle++;
    ii = lookup(opcode, fncode);
    w  = waitrequest;
    e_regdst = 0; e_pcsource = 0; e_memtoreg = 0; e_alusrcb = 0; e_aluop = 0;
    e_rw = 0; e_irw = 0; e_pcw = 0; e_pcwc = 0; e_jmp = 0; e_mr = 0; e_mw = 0;
    e_bne = 0; e_iord = 0; e_asa = 0;
    stall  = w && (m_state == 0 || (m_state == 2 && ii.ld) || (m_state == 3 && ii.st));
    expire = stall && (m_wd == TO - 1);
    if (m_state == 0) begin
      e_mr = 1; e_alusrcb = 2'd1; e_irw = !w; e_pcw = !w;
    end else if (m_state == 1) begin
      e_alusrcb = 2'd3;
    end else if (m_state == 2 || m_state == 3) begin
      e_regdst = ii.regdst; e_asa = ii.alusrca; e_alusrcb = ii.alusrcb; e_aluop = ii.aluop;
      e_pcsource = ii.pcsource; e_memtoreg = ii.memtoreg; e_iord = ii.iord; e_bne = ii.bne;
      if (m_state == 2) begin
        e_rw = (ii.wr_at == 2'd1); e_mr = ii.ld;
      end else begin
        e_rw = (ii.wr_at == 2'd2); e_jmp = ii.jmp; e_mw = ii.st; e_pcwc = ii.br;
      end
    end
    if (reset || expire) begin
      e_rw = 0; e_irw = 0; e_pcw = 0; e_pcwc = 0; e_jmp = 0; e_mr = 0; e_mw = 0;
    end
    e_act = !reset && (m_state != 4);

    if (m_valid) begin
      exp_v = {3'(m_state), e_act, e_regdst, e_rw, e_irw, e_pcw, e_pcwc, e_jmp, e_mr, e_mw,
               e_bne, e_iord, e_asa, e_pcsource, e_memtoreg, e_alusrcb, e_aluop, m_trap, m_timeout};
      act_v = {state, active, regdst, regwrite, irwrite, pcwrite, pcwritecond, jump, memread,
               memwrite, branch_ne, iord, alusrca, pcsource, memtoreg, alusrcb, aluop, trap, timeout};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL cycle %0d outputs (op=%h fn=%h): got %h, want %h, diff %h",
                 cycle, opcode, fncode, act_v, exp_v, act_v ^ exp_v);
      end
      o = '{st: state, act: active, rd: regdst, rw: regwrite, irw: irwrite, mr: memread,
            mw: memwrite, jmp: jump, trp: trap, tmo: timeout};
      obs_q.push_back(o);
    end

    if (reset) begin
      m_state = 0; m_wd = 0; m_trap = 0; m_timeout = 0;
    end else begin
      case (m_state)
        0: if (expire) m_state = 4; else if (!w) m_state = 1;
        1: m_state = 2;
        2: begin
          if (TRAP_EN && !ii.legal) begin m_state = 4; m_trap = 1; end
          else if (expire) m_state = 4;
          else if (ii.ld && w) m_state = 2;
          else m_state = 3;
        end
        3: begin
          if (expire) m_state = 4;
          else if (ii.st && w) m_state = 3;
          else if (ii.jmp && halt_req) m_state = 4;
          else m_state = 0;
        end
        default: m_state = 4;
      endcase
      if (expire) m_timeout = 1;
      if (!w) m_wd = 0;
      else if (stall) m_wd = m_wd + 1;
    end
    m_valid = 1;
  end

  // Driver tasks
  task automatic step(input logic wr, input logic hr);
    waitrequest = wr;
    halt_req = hr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step(1'b0, 1'b0);
    reset = 1'b0;
    obs_q.delete();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: observed state trace against the hand-written exp_q.
  task automatic check_states(input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) check($sformatf("%s state[%0d]", name, i), 32'(obs_q[i].st), 32'(exp_q[i]));
      else check($sformatf("%s trace length", name), 32'(obs_q.size()), 32'(exp_q.size()));
    end
  endtask

  function automatic int count_rw();
    int n = 0;
    foreach (obs_q[i]) n += int'(obs_q[i].rw);
    return n;
  endfunction

  function automatic int count_irw();
    int n = 0;
    foreach (obs_q[i]) n += int'(obs_q[i].irw);
    return n;
  endfunction

  // Directed instruction table: op, fn, halt_req, waitrequest per step (bit i = step i).
  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       hr;
    logic [7:0] wmask;
  } vec_t;

  vec_t vt[] = '{
    '{6'h00, 6'h23, 1'b0, 8'h00}, '{6'h00, 6'h24, 1'b0, 8'h00}, '{6'h00, 6'h25, 1'b0, 8'h03},
    '{6'h00, 6'h26, 1'b0, 8'h00}, '{6'h00, 6'h08, 1'b0, 8'h00}, '{6'h00, 6'h09, 1'b0, 8'h00},
    '{6'h09, 6'h3F, 1'b0, 8'h00}, '{6'h23, 6'h00, 1'b0, 8'h0C}, '{6'h2B, 6'h00, 1'b0, 8'h18},
    '{6'h04, 6'h00, 1'b0, 8'h00}, '{6'h05, 6'h00, 1'b0, 8'h00}, '{6'h02, 6'h00, 1'b0, 8'h00},
    '{6'h02, 6'h00, 1'b1, 8'h00}, '{6'h00, 6'h08, 1'b1, 8'h00}, '{6'h00, 6'h20, 1'b0, 8'h00},
    '{6'h04, 6'h00, 1'b1, 8'h00}, '{6'h2B, 6'h00, 1'b0, 8'h3F}
  };

  initial begin
    step(1'b0, 1'b0);

    // ADDU after a 3-cycle reset.
    do_reset(3);
    opcode = 6'h00; fncode = 6'h21;
    repeat (5) step(1'b0, 1'b0);
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    check_states("addu");
    check("addu reset active", 32'(obs_q[0].act), 32'd1);
    check("addu reset trap", 32'(obs_q[0].trp), 32'd0);
    check("addu reset timeout", 32'(obs_q[0].tmo), 32'd0);
    check("addu irwrite@1", 32'(obs_q[0].irw), 32'd1);
    check("addu regwrite@4", 32'(obs_q[3].rw), 32'd1);
    check("addu regdst@4", 32'(obs_q[3].rd), 32'd1);
    check("addu regwrite count", 32'(count_rw()), 32'd1);

    // LW with a 3-cycle stall in EXEC1.
    do_reset(1);
    opcode = 6'h23; fncode = 6'h00;
    foreach (exp_q[i]) ;
    step(0, 0); step(0, 0); step(1, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0); step(0, 0);
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd0};
    check_states("lw");
    for (int i = 2; i <= 5; i++) check($sformatf("lw memread[%0d]", i), 32'(obs_q[i].mr), 32'd1);
    check("lw regwrite@EXEC2", 32'(obs_q[6].rw), 32'd1);
    check("lw regwrite count", 32'(count_rw()), 32'd1);

    // JAL with halt_req: halts after EXEC2 and stays there.
    do_reset(1);
    opcode = 6'h03; fncode = 6'h00;
    repeat (7) step(1'b0, 1'b1);
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    check_states("jal");
    check("jal regwrite@EXEC1", 32'(obs_q[2].rw), 32'd1);
    check("jal regdst@EXEC1", 32'(obs_q[2].rd), 32'd2);
    check("jal jump@EXEC2", 32'(obs_q[3].jmp), 32'd1);
    check("jal active in HALT", 32'(obs_q[4].act), 32'd0);
    check("jal active still HALT", 32'(obs_q[6].act), 32'd0);

    // Watchdog: waitrequest stuck in FETCH.
    do_reset(1);
    opcode = 6'h00; fncode = 6'h21;
    repeat (8) step(1'b1, 1'b0);
    exp_q = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd4, 3'd4};
    check_states("watchdog");
    check("watchdog timeout before", 32'(obs_q[4].tmo), 32'd0);
    check("watchdog timeout after", 32'(obs_q[5].tmo), 32'd1);
    check("watchdog irwrite count", 32'(count_irw()), 32'd0);

    // Illegal opcode 3F.
    do_reset(1);
    opcode = 6'h3F; fncode = 6'h00;
    repeat (5) step(1'b0, 1'b0);
    if (TRAP_EN) begin
      exp_q = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd4};
      check("illegal trap", 32'(obs_q[3].trp), 32'd1);
    end else begin
      exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
      check("illegal trap", 32'(obs_q[4].trp), 32'd0);
    end
    check_states("illegal");
    check("illegal regwrite count", 32'(count_rw()), 32'd0);

    // Reset during an SW EXEC2 stall.
    do_reset(1);
    opcode = 6'h2B; fncode = 6'h00;
    step(0, 0); step(0, 0); step(0, 0); step(1, 0); step(1, 0);
    reset = 1'b1;
    step(1, 0);
    reset = 1'b0;
    step(0, 0);
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd0};
    check_states("sw reset");
    check("sw memwrite stall", 32'(obs_q[4].mw), 32'd1);
    check("sw memwrite in reset", 32'(obs_q[5].mw), 32'd0);
    check("sw active in reset", 32'(obs_q[5].act), 32'd0);

    // Remaining instruction mix, checked cycle by cycle against the model.
    foreach (vt[k]) begin
      do_reset(1);
      opcode = vt[k].op;
      fncode = vt[k].fn;
      for (int i = 0; i < 8; i++) step(vt[k].wmask[i], vt[k].hr);
    end

    do_reset(1);
    step(1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
